// File: rtl/pll_cen_gen.sv
`default_nettype none
// ============================================================================
// pll_cen_gen : lock-gated fractional clock-enable generator (num/den per ch)
// Revision    : 1.0
// ============================================================================
module pll_cen_gen #(
    parameter int                        NUM_CH    = 2,
    parameter int                        ACC_W     = 16,
    parameter int                        LOCK_WAIT = 1024,
    parameter logic [NUM_CH*ACC_W-1:0]   INIT_NUM  = {16'd1, 16'd1},
    parameter logic [NUM_CH*ACC_W-1:0]   INIT_DEN  = {16'd4, 16'd1}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pll_locked_i,
    input  logic                      ratio_load_i,
    input  logic [NUM_CH*ACC_W-1:0]   num_i,
    input  logic [NUM_CH*ACC_W-1:0]   den_i,
    output logic [NUM_CH-1:0]         cen_o,
    output logic                      ready_o,
    output logic                      rst_out_o,
    output logic [7:0]                lock_loss_cnt_o
);

    localparam int CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    // HOLDOFF is entered with the counter at 0, so the exit compare sits two
    // below LOCK_WAIT to give exactly LOCK_WAIT cycles from lk to ready.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((LOCK_WAIT >= 2) ? LOCK_WAIT - 2 : 0);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLDOFF   = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] holdoff, holdoff_nxt;
    logic             sync1, lk;
    logic             acc_en, lost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= pll_locked_i;
            lk    <= sync1;
        end
    end

    always_comb begin
        state_nxt   = state;
        holdoff_nxt = holdoff;
        case (state)
            WAIT_LOCK: begin
                holdoff_nxt = '0;
                if (lk)
                    state_nxt = (LOCK_WAIT <= 1) ? RUN : HOLDOFF;
            end
            HOLDOFF: begin
                if (!lk) begin
                    state_nxt   = WAIT_LOCK;
                    holdoff_nxt = '0;
                end else if (holdoff == HOLD_LAST) begin
                    state_nxt   = RUN;
                    holdoff_nxt = '0;
                end else begin
                    holdoff_nxt = holdoff + 1'b1;
                end
            end
            RUN: begin
                if (!lk)
                    state_nxt = WAIT_LOCK;
            end
            default: begin
                state_nxt   = WAIT_LOCK;
                holdoff_nxt = '0;
            end
        endcase
    end

    assign acc_en = (state == RUN) && lk && !ratio_load_i;
    assign lost   = (state == RUN) && !lk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= WAIT_LOCK;
            holdoff         <= '0;
            ready_o         <= 1'b0;
            rst_out_o       <= 1'b1;
            lock_loss_cnt_o <= 8'd0;
        end else begin
            state     <= state_nxt;
            holdoff   <= holdoff_nxt;
            ready_o   <= (state_nxt == RUN);
            rst_out_o <= (state_nxt != RUN);
            if (lost && (lock_loss_cnt_o != 8'hFF))
                lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] num_r, den_r, acc;
        logic [ACC_W:0]   sum, diff;
        logic             cen_r;

        assign sum     = {1'b0, acc} + {1'b0, num_r};
        assign diff    = sum - {1'b0, den_r};
        assign cen_o[i] = cen_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                num_r <= INIT_NUM[i*ACC_W +: ACC_W];
                den_r <= INIT_DEN[i*ACC_W +: ACC_W];
                acc   <= '0;
                cen_r <= 1'b0;
            end else begin
                if (ratio_load_i) begin
                    num_r <= num_i[i*ACC_W +: ACC_W];
                    den_r <= den_i[i*ACC_W +: ACC_W];
                end
                if (acc_en && (den_r != '0)) begin
                    if (sum >= {1'b0, den_r}) begin
                        // num>den can leave a residue above ACC_W bits; saturate instead of wrapping
                        acc   <= diff[ACC_W] ? '1 : diff[ACC_W-1:0];
                        cen_r <= 1'b1;
                    end else begin
                        acc   <= sum[ACC_W-1:0];
                        cen_r <= 1'b0;
                    end
                end else begin
                    acc   <= '0;
                    cen_r <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_cen_gen.sv
`default_nettype none
// ============================================================================
// tb_pll_cen_gen : scoreboard bench with a cycle-level behavioural model
// Revision       : 1.0
// ============================================================================
module tb_pll_cen_gen;

    localparam int LW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_locked_i = 1'b0;
    logic        ratio_load_i = 1'b0;
    logic [31:0] num_i = '0;
    logic [31:0] den_i = '0;
    logic [1:0]  cen_o;
    logic        ready_o;
    logic        rst_out_o;
    logic [7:0]  lock_loss_cnt_o;

    pll_cen_gen #(.NUM_CH(2), .ACC_W(16), .LOCK_WAIT(LW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_locked_i    (pll_locked_i),
        .ratio_load_i    (ratio_load_i),
        .num_i           (num_i),
        .den_i           (den_i),
        .cen_o           (cen_o),
        .ready_o         (ready_o),
        .rst_out_o       (rst_out_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] cen;
        logic       ready;
        logic       rst_out;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: ready means the synchronised lock has been high for the
    // last LOCK_WAIT cycles; a channel pulses when floor(k*num/den) steps up,
    // k counting accumulating cycles since the last realignment.
    int     m_prev_raw, m_ones, m_cnt;
    bit     m_ready, m_rdy_new, m_acc, m_lk_new;
    longint m_k[2], m_num[2], m_den[2];
    logic [1:0] m_cen;
    exp_t   m_e;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_prev_raw = 0; m_ones = 0; m_cnt = 0; m_ready = 0;
            m_num[0] = 1; m_den[0] = 1; m_num[1] = 1; m_den[1] = 4;
            m_k[0] = 0; m_k[1] = 0;
            m_cen = 2'b00;
        end else begin
            m_rdy_new = (m_ones >= LW);
            m_acc = m_ready && m_rdy_new && !ratio_load_i;
            for (int c = 0; c < 2; c++) begin
                if (m_acc) begin
                    m_k[c] = m_k[c] + 1;
                    m_cen[c] = (m_den[c] != 0) &&
                               ((m_k[c] * m_num[c]) / m_den[c] > ((m_k[c] - 1) * m_num[c]) / m_den[c]);
                end else begin
                    m_k[c] = 0;
                    m_cen[c] = 1'b0;
                end
            end
            if (ratio_load_i) begin
                m_num[0] = longint'(num_i[15:0]);  m_den[0] = longint'(den_i[15:0]);
                m_num[1] = longint'(num_i[31:16]); m_den[1] = longint'(den_i[31:16]);
            end
            if (m_ready && !m_rdy_new && m_cnt < 255) m_cnt = m_cnt + 1;
            m_ready = m_rdy_new;
            m_lk_new = (m_prev_raw != 0);
            m_prev_raw = int'(pll_locked_i);
            m_ones = m_lk_new ? ((m_ones < LW) ? m_ones + 1 : LW) : 0;
        end
        m_e.cen = m_cen; m_e.ready = m_ready; m_e.rst_out = !m_ready; m_e.cnt = 8'(m_cnt);
        q.push_back(m_e);
    end

    exp_t mon_e, mon_g;
    always @(negedge clk) begin
        checks++;
        if (q.size() == 0) begin
            $display("FAIL scoreboard_underflow t=%0t no expected entry", $time);
        end else begin
            mon_e = q.pop_front();
            mon_g = {cen_o, ready_o, rst_out_o, lock_loss_cnt_o};
            if (mon_g === mon_e) passed++;
            else $display("FAIL outputs t=%0t got cen=%b rdy=%b rst=%b cnt=%0d exp cen=%b rdy=%b rst=%b cnt=%0d",
                          $time, mon_g.cen, mon_g.ready, mon_g.rst_out, mon_g.cnt,
                          mon_e.cen, mon_e.ready, mon_e.rst_out, mon_e.cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [31:0] n, input logic [31:0] d);
        num_i = n; den_i = d; ratio_load_i = 1'b1;
        tick(1);
        ratio_load_i = 1'b0;
    endtask

    task automatic direct(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(5);
        pll_locked_i = 1'b1;           // lock acquisition and default 1/1, 1/4
        tick(LW + 8);
        tick(40);
        load({16'd3, 16'd1}, {16'd7, 16'd1});
        tick(50);
        pll_locked_i = 1'b0;           // glitch during HOLDOFF restarts the holdoff
        tick(4);
        pll_locked_i = 1'b1;
        tick(6);
        pll_locked_i = 1'b0;
        tick(1);
        pll_locked_i = 1'b1;
        tick(LW + 8);
        repeat (300) begin
            pll_locked_i = 1'b0;
            tick($urandom_range(1, 3));
            pll_locked_i = 1'b1;
            tick(LW + 4 + $urandom_range(0, 6));
        end
        direct("lock_loss_saturated", int'(lock_loss_cnt_o), 255);
        load({16'd0, 16'd1}, {16'd5, 16'd0});
        tick(30);
        repeat (40) begin
            logic [15:0] d0, d1, n0, n1;
            d0 = 16'($urandom_range(0, 12)); n0 = 16'($urandom_range(0, int'(d0)));
            d1 = 16'($urandom_range(0, 12)); n1 = 16'($urandom_range(0, int'(d1)));
            load({n1, n0}, {d1, d0});
            tick($urandom_range(5, 40));
            if ($urandom_range(0, 3) == 0) begin
                pll_locked_i = 1'b0;
                tick($urandom_range(1, 2));
                pll_locked_i = 1'b1;
                tick(LW + 4);
            end
        end
        pll_locked_i = 1'b0;           // ratio load on the same edge as lock loss
        tick(2);
        load({16'd2, 16'd1}, {16'd5, 16'd3});
        pll_locked_i = 1'b1;
        tick(LW + 20);
        rst_n = 1'b0;                  // asynchronous reset mid-RUN
        #1;
        direct("async_rst_cen", int'(cen_o), 0);
        direct("async_rst_ready", int'(ready_o), 0);
        direct("async_rst_rst_out", int'(rst_out_o), 1);
        direct("async_rst_cnt", int'(lock_loss_cnt_o), 0);
        tick(2);
        rst_n = 1'b1;
        tick(LW + 6);
        tick(30);
        tick(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_cen_gen.md
Name: pll_cen_gen

Overview:
- Parametrised multi-channel clock-enable generator that follows the core PLL.
- Runs on a single PLL output clock and derives NUM_CH fractional-rate clock-enable pulses (num/den per channel) using phase accumulators, so downstream logic needs no extra PLL outputs.
- Gates every enable, and a downstream reset, on a synchronised, debounced PLL lock.
- Counts lock-loss events and supports runtime ratio reload with phase realignment.

Parameters:
- NUM_CH, 2, number of enable channels (1..8).
- ACC_W, 16, accumulator/ratio width per channel.
- LOCK_WAIT, 1024, cycles of continuous synchronised lock before RUN (>=1).
- INIT_NUM, {16'd1,16'd1}, flattened per-channel reset numerators; channel 0 is in LSBs.
- INIT_DEN, {16'd4,16'd1}, flattened per-channel reset denominators; ch0=1/1, ch1=1/4.

Ports:
- clk  in  1  single clock (PLL output); all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked_i  in  1  raw PLL lock, asynchronous to clk.
- ratio_load_i  in  1  one-cycle strobe; captures num_i/den_i.
- num_i  in  NUM_CH*ACC_W  per-channel numerators.
- den_i  in  NUM_CH*ACC_W  per-channel denominators.
- cen_o  out  NUM_CH  registered clock-enable pulses, one cycle wide.
- ready_o  out  1  high while in RUN.
- rst_out_o  out  1  active-high downstream reset, equal to ~ready_o (registered).
- lock_loss_cnt_o  out  8  saturating count of RUN->WAIT_LOCK transitions.

Behaviour:
- Reset (rst_n low, async):
  - state=WAIT_LOCK, synchroniser=0, holdoff counter=0.
  - acc[i]=0, num/den registers=INIT_NUM/INIT_DEN.
  - cen_o=0, ready_o=0, rst_out_o=1, lock_loss_cnt_o=0.
- Lock sync: 2-FF synchroniser on pll_locked_i, giving lk. Raw-to-lk latency is 2 edges.
- FSM:
  - WAIT_LOCK: holdoff=0. If lk=1, go to HOLDOFF.
  - HOLDOFF: holdoff increments each cycle lk=1. If lk=0, go to WAIT_LOCK, counter cleared. On the edge where the counter reaches LOCK_WAIT-1 with lk=1, go to RUN and clear all acc.
  - RUN: if lk=0, go to WAIT_LOCK, clear acc, set cen_o=0 on that same edge, and increment lock_loss_cnt_o (saturates at 255).
- Outputs outside RUN: ready_o=1 only in RUN (registered state decode). cen_o is forced 0 in every non-RUN state.
- Accumulator, per channel per RUN edge:
  - sum = acc + num, computed at ACC_W+1 bits.
  - If den!=0 and sum>=den: acc<=sum-den and cen_o[i]<=1.
  - Otherwise: acc<=sum and cen_o[i]<=0.
- Accumulator boundary cases:
  - num=0: never pulses.
  - num=den: pulses every cycle.
  - den=0: channel disabled, cen 0, acc held 0.
  - num>den: unsupported; in that case acc is clamped (sum-den retained), no overflow wrap required.
- Phase: after the entry edge E0 into RUN (acc=0), a ratio of 1/d first raises cen_o after edge E_d, then every d edges. All channels are aligned at E0.
- ratio_load_i:
  - On the strobe edge, num/den registers take num_i/den_i for all channels.
  - In RUN, the same edge clears all acc and forces cen_o=0 (realign). The new ratio is counted from the next edge.
  - Outside RUN it only updates the registers.
- Simultaneous ratio_load_i and lock loss in RUN: registers update, state goes to WAIT_LOCK, counter increments.
- rst_n asserted mid-RUN: immediate return to reset values, including INIT ratios.

Test Plan:
1. Reset, then pll_locked_i=1 steady (LOCK_WAIT=16 in bench) -> ready_o rises exactly 2+16 edges after lock rises. rst_out_o=1 until then. cen_o=0 throughout.
2. Default ratios in RUN -> cen_o[0]=1 every cycle from E1. cen_o[1] high at E4, E8, E12, … (25% duty), all pulses one cycle wide.
3. Load ratio 3/7 on ch1 in RUN -> exactly 3 pulses per 7-cycle window. Pattern starts from acc=0 on the cycle after the load. cen_o=0 on the load edge.
4. Drop pll_locked_i for 1 cycle during HOLDOFF -> counter restarts; ready_o is delayed a full LOCK_WAIT after lk returns. lock_loss_cnt_o unchanged.
5. Drop lock in RUN 300 times -> cen_o and ready_o fall within 3 edges of each drop. lock_loss_cnt_o saturates at 255.
6. den=0 on ch0 and num=0 on ch1 -> both cen_o stay 0 in RUN. Assert rst_n mid-RUN -> all outputs return to reset values asynchronously and ratios revert to 1/1 and 1/4.
